// File: rtl/eh2_lsu_dccm_arb_pkg.sv
// Shared types for the DCCM arbiter slice.
// State and requester encodings.
package eh2_lsu_dccm_arb_pkg;

  typedef enum logic [1:0] {
    NORMAL,
    DMA_URGENT,
    QUIESCE
  } eh2_dccm_arb_state_e;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_ECC,
    REQ_LSU,
    REQ_DMA,
    REQ_STBUF
  } eh2_dccm_req_e;

endpackage

// File: rtl/eh2_lsu_dccm_rsp_pipe.sv
// DMA read response pipe: RD_LAT-deep valid/tag shift register.
// empty_nxt: nothing will be in flight next cycle.
module eh2_lsu_dccm_rsp_pipe #(
  parameter int RD_LAT = 1,
  parameter int TAG_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  output logic             rsp_valid,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             empty_nxt
);

  logic [RD_LAT-1:0] vld_q;
  logic [TAG_W-1:0]  tag_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= push;
      tag_q[0] <= push ? push_tag : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign rsp_valid = vld_q[RD_LAT-1];
  assign rsp_tag   = tag_q[RD_LAT-1];

  // The last stage leaves the pipe this cycle.
  generate
    if (RD_LAT > 1) begin : g_deep
      assign empty_nxt = !push && !(|vld_q[RD_LAT-2:0]);
    end else begin : g_one
      assign empty_nxt = !push;
    end
  endgenerate

endmodule

// File: rtl/eh2_lsu_dccm_arb.sv
// Single-port banked DCCM arbiter: ECC, LSU read, DMA, store buffer.
// Tracks DMA read responses, DMA starvation and quiesce.
module eh2_lsu_dccm_arb
  import eh2_lsu_dccm_arb_pkg::*;
#(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int RD_LAT           = 1,
  parameter int DMA_STARVE_MAX   = 15,
  parameter int DMA_TAG_W        = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lsu_rd_valid,
  output logic                        lsu_rd_ready,
  input  logic [DCCM_BITS-1:0]        lsu_addr_lo,
  input  logic [DCCM_BITS-1:0]        lsu_addr_hi,
  input  logic                        ecc_corr_valid,
  input  logic [DCCM_BITS-1:0]        ecc_corr_addr_lo,
  input  logic [DCCM_BITS-1:0]        ecc_corr_addr_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] ecc_corr_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] ecc_corr_data_hi,
  input  logic                        dma_valid,
  input  logic                        dma_write,
  input  logic [DMA_TAG_W-1:0]        dma_tag,
  input  logic [DCCM_BITS-1:0]        dma_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] dma_wdata,
  output logic                        dma_ready,
  output logic                        dma_rsp_valid,
  output logic [DMA_TAG_W-1:0]        dma_rsp_tag,
  input  logic                        stbuf_valid,
  input  logic                        stbuf_full,
  output logic                        stbuf_ready,
  input  logic [DCCM_BITS-1:0]        stbuf_addr_lo,
  input  logic [DCCM_BITS-1:0]        stbuf_addr_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0] stbuf_data_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0] stbuf_data_hi,
  input  logic                        quiesce_req,
  output logic                        quiesce_ack,
  output logic                        dccm_wren,
  output logic                        dccm_rden,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]        dccm_rd_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi
);

  localparam int CNT_W = $clog2(DMA_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DMA_STARVE_MAX);

  eh2_dccm_arb_state_e state_q;
  eh2_dccm_req_e       win;

  logic [CNT_W-1:0]            cnt_q;
  logic                        ecc_pend_q;
  logic [DCCM_BITS-1:0]        ecc_addr_lo_q;
  logic [DCCM_BITS-1:0]        ecc_addr_hi_q;
  logic [DCCM_FDATA_WIDTH-1:0] ecc_data_lo_q;
  logic [DCCM_FDATA_WIDTH-1:0] ecc_data_hi_q;
  logic                        ack_q;
  logic                        stb_urgent;
  logic                        dma_grant;
  logic                        pipe_empty_nxt;

  assign stb_urgent = stbuf_valid && stbuf_full;

  // Winner select; ECC write-back always goes first.
  always_comb begin
    win = REQ_NONE;
    if (rst) begin
      win = REQ_NONE;
    end else if (ecc_pend_q) begin
      win = REQ_ECC;
    end else begin
      case (state_q)
        NORMAL: begin
          if (stb_urgent)        win = REQ_STBUF;
          else if (lsu_rd_valid) win = REQ_LSU;
          else if (dma_valid)    win = REQ_DMA;
          else if (stbuf_valid)  win = REQ_STBUF;
        end
        DMA_URGENT: begin
          if (dma_valid)         win = REQ_DMA;
          else if (stb_urgent)   win = REQ_STBUF;
          else if (lsu_rd_valid) win = REQ_LSU;
          else if (stbuf_valid)  win = REQ_STBUF;
        end
        default: win = REQ_NONE;
      endcase
    end
  end

  assign lsu_rd_ready = (win == REQ_LSU);
  assign dma_ready    = (win == REQ_DMA);
  assign stbuf_ready  = (win == REQ_STBUF);
  assign dma_grant    = dma_ready;
  assign quiesce_ack  = ack_q;

  always_comb begin
    dccm_wren       = 1'b0;
    dccm_rden       = 1'b0;
    dccm_wr_addr_lo = '0;
    dccm_wr_addr_hi = '0;
    dccm_rd_addr_lo = '0;
    dccm_rd_addr_hi = '0;
    dccm_wr_data_lo = '0;
    dccm_wr_data_hi = '0;
    case (win)
      REQ_ECC: begin
        dccm_wren       = 1'b1;
        dccm_wr_addr_lo = ecc_addr_lo_q;
        dccm_wr_addr_hi = ecc_addr_hi_q;
        dccm_wr_data_lo = ecc_data_lo_q;
        dccm_wr_data_hi = ecc_data_hi_q;
      end
      REQ_STBUF: begin
        dccm_wren       = 1'b1;
        dccm_wr_addr_lo = stbuf_addr_lo;
        dccm_wr_addr_hi = stbuf_addr_hi;
        dccm_wr_data_lo = stbuf_data_lo;
        dccm_wr_data_hi = stbuf_data_hi;
      end
      REQ_LSU: begin
        dccm_rden       = 1'b1;
        dccm_rd_addr_lo = lsu_addr_lo;
        dccm_rd_addr_hi = lsu_addr_hi;
      end
      REQ_DMA: begin
        if (dma_write) begin
          dccm_wren       = 1'b1;
          dccm_wr_addr_lo = dma_addr;
          dccm_wr_addr_hi = dma_addr;
          dccm_wr_data_lo = dma_wdata;
          dccm_wr_data_hi = dma_wdata;
        end else begin
          dccm_rden       = 1'b1;
          dccm_rd_addr_lo = dma_addr;
          dccm_rd_addr_hi = dma_addr;
        end
      end
      default: ;
    endcase
  end

  // A fresh pulse always reloads; the old entry issues this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ecc_pend_q    <= 1'b0;
      ecc_addr_lo_q <= '0;
      ecc_addr_hi_q <= '0;
      ecc_data_lo_q <= '0;
      ecc_data_hi_q <= '0;
    end else begin
      ecc_pend_q <= ecc_corr_valid;
      if (ecc_corr_valid) begin
        ecc_addr_lo_q <= ecc_corr_addr_lo;
        ecc_addr_hi_q <= ecc_corr_addr_hi;
        ecc_data_lo_q <= ecc_corr_data_lo;
        ecc_data_hi_q <= ecc_corr_data_hi;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (dma_grant) begin
      cnt_q <= '0;
    end else if (dma_valid && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NORMAL;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= (state_q == QUIESCE) && quiesce_req &&
               pipe_empty_nxt && !ecc_corr_valid;
      case (state_q)
        NORMAL: begin
          if (quiesce_req)
            state_q <= QUIESCE;
          else if ((cnt_q == CNT_MAX) && dma_valid)
            state_q <= DMA_URGENT;
        end
        DMA_URGENT: begin
          if (quiesce_req)    state_q <= QUIESCE;
          else if (dma_grant) state_q <= NORMAL;
        end
        QUIESCE: begin
          if (!quiesce_req) state_q <= NORMAL;
        end
        default: state_q <= NORMAL;
      endcase
    end
  end

  eh2_lsu_dccm_rsp_pipe #(
    .RD_LAT (RD_LAT),
    .TAG_W  (DMA_TAG_W)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (dma_grant && !dma_write),
    .push_tag  (dma_tag),
    .rsp_valid (dma_rsp_valid),
    .rsp_tag   (dma_rsp_tag),
    .empty_nxt (pipe_empty_nxt)
  );

endmodule
